// File: rtl/hamming_serial_encoder.sv
`timescale 1ns/1ps
// Serial Hamming(7,4) encoder: buffers nibbles in a small FIFO, encodes each
// to a 7-bit codeword and shifts it out LSB-first framed by dataIncoming.
module hamming_serial_encoder #(
    parameter int FIFO_DEPTH = 2,
    parameter int GAP_CYCLES = 5
) (
    input  logic       clock,
    input  logic       resetN,
    input  logic       inValid,
    output logic       inReady,
    input  logic [3:0] inData,
    input  logic       injectErr,
    input  logic [2:0] injectPos,
    output logic       dataIncoming,
    output logic       dataIn,
    output logic       busy,
    output logic       frameErr
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam logic [CW-1:0] COUNT_FULL = CW'(FIFO_DEPTH);
    localparam logic [GW-1:0] GAP_LAST   = GW'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    function automatic logic [6:0] hamming_encode(input logic [3:0] d);
        logic p0;
        logic p1;
        logic p2;
        p0 = d[0] ^ d[1] ^ d[3];
        p1 = d[1] ^ d[2] ^ d[3];
        p2 = d[0] ^ d[2] ^ d[3];
        return {d, p2, p1, p0};
    endfunction

    // Position 7 is the "no corruption" code.
    function automatic logic [6:0] flip_mask(input logic inject, input logic [2:0] pos);
        logic [6:0] mask;
        if (inject && (pos != 3'd7)) begin
            mask = 7'b0000001 << pos;
        end else begin
            mask = 7'b0000000;
        end
        return mask;
    endfunction

    logic [7:0]    mem_r [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          full_s;
    logic          empty_s;
    logic          push_s;
    logic          pop_s;
    logic [7:0]    entry_s;
    logic [7:0]    head_s;

    state_t        state_r;
    state_t        state_s;
    logic [6:0]    shifter_r;
    logic [6:0]    shifter_s;
    logic [2:0]    bit_idx_r;
    logic [2:0]    bit_idx_s;
    logic [GW-1:0] gap_cnt_r;
    logic [GW-1:0] gap_cnt_s;
    logic          data_incoming_r;
    logic          data_incoming_s;
    logic          data_in_r;
    logic          data_in_s;
    logic          frame_err_r;
    logic          frame_err_s;

    assign full_s  = (count_r == COUNT_FULL);
    assign empty_s = (count_r == {CW{1'b0}});
    assign push_s  = inValid && !full_s;
    assign head_s  = mem_r[rd_ptr_r];
    assign entry_s = {injectErr && (injectPos != 3'd7),
                      hamming_encode(inData) ^ flip_mask(injectErr, injectPos)};

    // FIFO storage, pointers and occupancy.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= 8'h00;
            end
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= entry_s;
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Frame sequencing: next state, shifter, counters and next output values.
    always_comb begin
        state_s         = state_r;
        shifter_s       = shifter_r;
        bit_idx_s       = bit_idx_r;
        gap_cnt_s       = gap_cnt_r;
        data_incoming_s = 1'b0;
        data_in_s       = 1'b0;
        frame_err_s     = frame_err_r;
        pop_s           = 1'b0;
        case (state_r)
            ST_IDLE: begin
                frame_err_s = 1'b0;
                if (!empty_s) begin
                    pop_s       = 1'b1;
                    shifter_s   = head_s[6:0];
                    frame_err_s = head_s[7];
                    bit_idx_s   = 3'd0;
                    state_s     = ST_SHIFT;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                data_incoming_s = 1'b1;
                data_in_s       = shifter_r[bit_idx_r];
                if (bit_idx_r == 3'd6) begin
                    bit_idx_s = 3'd0;
                    gap_cnt_s = {GW{1'b0}};
                    state_s   = ST_GAP;
                end else begin
                    bit_idx_s = bit_idx_r + 3'd1;
                end
            end
            ST_GAP: begin
                if (gap_cnt_r == GAP_LAST) begin
                    gap_cnt_s   = {GW{1'b0}};
                    frame_err_s = 1'b0;
                    state_s     = ST_IDLE;
                end else begin
                    gap_cnt_s = gap_cnt_r + GW'(1);
                end
            end
            default: begin
                frame_err_s = 1'b0;
                state_s     = ST_IDLE;
            end
        endcase
    end

    // State and registered serial outputs.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_r         <= ST_IDLE;
            shifter_r       <= 7'd0;
            bit_idx_r       <= 3'd0;
            gap_cnt_r       <= {GW{1'b0}};
            data_incoming_r <= 1'b0;
            data_in_r       <= 1'b0;
            frame_err_r     <= 1'b0;
        end else begin
            state_r         <= state_s;
            shifter_r       <= shifter_s;
            bit_idx_r       <= bit_idx_s;
            gap_cnt_r       <= gap_cnt_s;
            data_incoming_r <= data_incoming_s;
            data_in_r       <= data_in_s;
            frame_err_r     <= frame_err_s;
        end
    end

    assign inReady      = !full_s;
    assign busy         = (state_r != ST_IDLE) || !empty_s;
    assign dataIncoming = data_incoming_r;
    assign dataIn       = data_in_r;
    assign frameErr     = frame_err_r;

endmodule

// File: tb/tb_hamming_serial_encoder.sv
`timescale 1ns/1ps
// Bench for hamming_serial_encoder: a frame-level reference model predicts
// every output each cycle; directed and random words exercise it.
module tb_hamming_serial_encoder;

    localparam int DEPTH = 2;
    localparam int GAP   = 5;
    localparam int LAST  = 7 + GAP;

    logic       clock     = 1'b0;
    logic       resetN    = 1'b0;
    logic       inValid   = 1'b0;
    logic [3:0] inData    = 4'd0;
    logic       injectErr = 1'b0;
    logic [2:0] injectPos = 3'd7;
    logic       inReady;
    logic       dataIncoming;
    logic       dataIn;
    logic       busy;
    logic       frameErr;

    hamming_serial_encoder #(.FIFO_DEPTH(DEPTH), .GAP_CYCLES(GAP)) dut (
        .clock(clock), .resetN(resetN), .inValid(inValid), .inReady(inReady),
        .inData(inData), .injectErr(injectErr), .injectPos(injectPos),
        .dataIncoming(dataIncoming), .dataIn(dataIn), .busy(busy), .frameErr(frameErr)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    // Each parity bit covers the data bits selected by its mask.
    function automatic logic [6:0] model_encode(input logic [3:0] d);
        return {d, ^(d & 4'b1101), ^(d & 4'b1110), ^(d & 4'b1011)};
    endfunction

    function automatic logic [7:0] model_entry(input logic [3:0] d, input logic inj, input int pos);
        logic [6:0] m;
        m = 7'd0;
        if (inj && pos < 7) m[pos] = 1'b1;
        return {inj && (pos < 7), model_encode(d) ^ m};
    endfunction

    // Reference model: word queue plus "edges since last pop" frame timer.
    logic [7:0] mq[$];
    int         since    = -1;
    logic [7:0] cur      = 8'd0;
    bit         acc_last = 1'b0;
    int         done     = 0;

    always @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            mq.delete();
            since    = -1;
            acc_last = 1'b0;
        end else begin
            int pre;
            pre      = mq.size();
            acc_last = inValid && (pre < DEPTH);
            if (since < 0 || since >= LAST) begin
                if (mq.size() > 0) begin
                    cur   = mq.pop_front();
                    since = 0;
                end else begin
                    since = -1;
                end
            end else begin
                since++;
                if (since == 8) done++;
            end
            if (acc_last) mq.push_back(model_entry(inData, injectErr, int'(injectPos)));
        end
    end

    logic [6:0] capw       = 7'd0;
    logic [6:0] last_frame = 7'd0;
    logic       last_err   = 1'b0;
    int         hi_len     = 0;
    int         frames     = 0;

    // Per-cycle compare against the model, plus serial frame capture.
    always @(negedge clock) begin
        int   s;
        logic ei, ed, ef, eb, er;
        s  = since;
        ei = (s >= 1 && s <= 7);
        ed = ei ? cur[s-1] : 1'b0;
        ef = (s >= 0 && s < LAST) ? cur[7] : 1'b0;
        eb = (s >= 0 && s < LAST) || (mq.size() > 0);
        er = (mq.size() < DEPTH);
        chk("dataIncoming", int'(dataIncoming), int'(ei));
        chk("dataIn", int'(dataIn), int'(ed));
        chk("frameErr", int'(frameErr), int'(ef));
        chk("busy", int'(busy), int'(eb));
        chk("inReady", int'(inReady), int'(er));
        if (!resetN) begin
            hi_len = 0;
        end else if (dataIncoming) begin
            if (hi_len < 7) capw[hi_len] = dataIn;
            hi_len++;
            last_err = frameErr;
        end else if (hi_len > 0) begin
            chk("frame_len", hi_len, 7);
            frames++;
            last_frame = capw;
            hi_len = 0;
        end
    end

    task automatic send(input logic [3:0] d, input logic inj, input logic [2:0] pos);
        int n;
        n = 0;
        inValid = 1'b1; inData = d; injectErr = inj; injectPos = pos;
        do begin
            @(negedge clock);
            n++;
        end while (!acc_last && n < 40);
        if (!acc_last) chk("send_timeout", 0, 1);
        inValid = 1'b0; injectErr = 1'b0; injectPos = 3'd7;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((mq.size() > 0 || (since >= 0 && since < LAST)) && n < 300) begin
            @(negedge clock);
            n++;
        end
        chk("drain_timeout", int'(n < 300), 1);
        repeat (2) @(negedge clock);
    endtask

    initial begin
        int f0;
        int n;
        chk("model_enc_1010", int'(model_encode(4'b1010)), int'(7'b1010100));
        chk("model_inj_pos3", int'(model_entry(4'b0000, 1'b1, 3)), int'(8'b10001000));
        chk("model_inj_pos7", int'(model_entry(4'b0000, 1'b1, 7)), int'(8'h00));

        // Reset: inValid while in reset is ignored.
        inValid = 1'b1;
        repeat (3) @(negedge clock);
        chk("rst_inReady", int'(inReady), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_dataIncoming", int'(dataIncoming), 0);
        inValid = 1'b0;
        resetN  = 1'b1;
        repeat (2) @(negedge clock);

        f0 = frames;
        send(4'b1010, 1'b0, 3'd7);
        drain();
        chk("t1_frames", frames - f0, 1);
        chk("t1_code", int'(last_frame), int'(7'b1010100));
        chk("t1_ferr", int'(last_err), 0);
        chk("t1_busy_low", int'(busy), 0);

        send(4'b0000, 1'b1, 3'd3);
        drain();
        chk("t3_code_pos3", int'(last_frame), int'(7'b0001000));
        chk("t3_ferr_pos3", int'(last_err), 1);
        send(4'b0000, 1'b1, 3'd7);
        drain();
        chk("t3_code_pos7", int'(last_frame), int'(7'b0000000));
        chk("t3_ferr_pos7", int'(last_err), 0);

        // All nibbles back to back: FIFO fills and pushes stall at full.
        f0 = frames;
        for (int d = 0; d < 16; d++) send(4'(d), 1'b0, 3'd7);
        drain();
        chk("t2_frames", frames - f0, 16);

        // Reset in the middle of a frame, at bit 3.
        f0 = frames;
        send(4'b1111, 1'b1, 3'd2);
        n = 0;
        while (since != 4 && n < 40) begin
            @(negedge clock);
            n++;
        end
        chk("t4_reach_bit3", since, 4);
        #1 resetN = 1'b0;
        inValid = 1'b1;
        #1;
        chk("t4_dataIncoming", int'(dataIncoming), 0);
        chk("t4_dataIn", int'(dataIn), 0);
        chk("t4_frameErr", int'(frameErr), 0);
        chk("t4_busy", int'(busy), 0);
        chk("t4_inReady", int'(inReady), 1);
        repeat (2) @(negedge clock);
        inValid = 1'b0;
        resetN  = 1'b1;
        repeat (20) @(negedge clock);
        chk("t4_no_resume", frames - f0, 0);

        // Random words with random idle gaps and injections.
        f0 = frames;
        for (int i = 0; i < 60; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clock);
            send(4'($urandom_range(0, 15)), 1'($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)));
        end
        drain();
        chk("rand_frames", frames - f0, 60);
        chk("frame_total", frames, done);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
